// File: rtl/vga_timing_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundles the pixel-enable input and all raster outputs of vga_timing_gen.
//   HW/VW must match the counter widths the generator derives from its
//   H_TOTAL/V_TOTAL ($clog2 of each).
//
//   Signals
//     en           pixel enable (consumer -> generator)
//     h_cnt/v_cnt  raw raster counters
//     fetch_*      fetch-side coordinates, valid in the active area
//     tile_*       fetch coordinates divided by 2^SCALE_SHIFT
//     line_start   strobe at the start of each active line (fetch side)
//     frame_start  strobe at the start of each frame (fetch side)
//     hsync/vsync/de  display-side signals, delayed PREFETCH enables
//
//   Modports
//     master  the timing generator
//     slave   the pixel pipeline / display consumer
// ----------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int HW = 11,
  parameter int VW = 10
);
  logic          en;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          fetch_valid;
  logic [HW-1:0] fetch_x;
  logic [VW-1:0] fetch_y;
  logic [HW-1:0] tile_x;
  logic [VW-1:0] tile_y;
  logic          line_start;
  logic          frame_start;
  logic          hsync;
  logic          vsync;
  logic          de;

  modport master (
    input  en,
    output h_cnt, v_cnt, fetch_valid, fetch_x, fetch_y, tile_x, tile_y,
    output line_start, frame_start, hsync, vsync, de
  );

  modport slave (
    output en,
    input  h_cnt, v_cnt, fetch_valid, fetch_x, fetch_y, tile_x, tile_y,
    input  line_start, frame_start, hsync, vsync, de
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator. Counts pixels/lines in the order
//   active, front porch, sync, back porch. Fetch coordinates and strobes are
//   produced straight from the counters; hsync/vsync/de are pushed through a
//   PREFETCH-deep shift register so that a pixel fetched now is displayed
//   exactly PREFETCH enabled cycles later, hiding pixel memory read latency.
//
//   Ports
//     clk   pixel clock
//     rst   asynchronous, active-low reset
//     bus   vga_timing_gen_if.master (en in, all raster outputs out)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 56,
  parameter int H_SYNC      = 120,
  parameter int H_BP        = 64,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 37,
  parameter int V_SYNC      = 6,
  parameter int V_BP        = 23,
  parameter bit H_POL       = 1'b1,
  parameter bit V_POL       = 1'b1,
  parameter int PREFETCH    = 2,
  parameter int SCALE_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  // With no back porch the sync end equals the total, which may not fit the
  // counter width; the pulse then simply runs to the end of the line/frame.
  localparam bit            HS_TO_END  = (H_BP == 0);
  localparam bit            VS_TO_END  = (V_BP == 0);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } pipeStage_t;

  localparam pipeStage_t RESET_STAGE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0};

  logic [HW-1:0] r_hCnt;
  logic [VW-1:0] r_vCnt;
  pipeStage_t    r_pipe [PREFETCH];

  logic          w_fetchValid;
  logic [HW-1:0] w_fetchX;
  logic [VW-1:0] w_fetchY;
  logic          w_hsPulse;
  logic          w_vsPulse;
  pipeStage_t    w_raw;

  assign w_fetchValid = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
  assign w_fetchX     = w_fetchValid ? r_hCnt : '0;
  assign w_fetchY     = w_fetchValid ? r_vCnt : '0;
  assign w_hsPulse    = (r_hCnt >= HS_START) && (HS_TO_END || (r_hCnt < HS_END));
  assign w_vsPulse    = (r_vCnt >= VS_START) && (VS_TO_END || (r_vCnt < VS_END));
  assign w_raw.hs     = w_hsPulse ? H_POL : ~H_POL;
  assign w_raw.vs     = w_vsPulse ? V_POL : ~V_POL;
  assign w_raw.de     = w_fetchValid;

  // Raster counters and the display-side delay line. Everything holds while
  // en is low; stage 0 captures the decode of the position being fetched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
      for (int i = 0; i < PREFETCH; i++) begin
        r_pipe[i] <= RESET_STAGE;
      end
    end else if (bus.en) begin
      if (r_hCnt == H_LAST) begin
        r_hCnt <= '0;
        r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + VW'(1);
      end else begin
        r_hCnt <= r_hCnt + HW'(1);
      end
      r_pipe[0] <= w_raw;
      for (int i = 1; i < PREFETCH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign bus.h_cnt       = r_hCnt;
  assign bus.v_cnt       = r_vCnt;
  assign bus.fetch_valid = w_fetchValid;
  assign bus.fetch_x     = w_fetchX;
  assign bus.fetch_y     = w_fetchY;
  assign bus.tile_x      = w_fetchX >> SCALE_SHIFT;
  assign bus.tile_y      = w_fetchY >> SCALE_SHIFT;
  assign bus.line_start  = bus.en && (r_hCnt == '0) && (r_vCnt < V_ACT);
  assign bus.frame_start = bus.en && (r_hCnt == '0) && (r_vCnt == '0);
  assign bus.hsync       = r_pipe[PREFETCH-1].hs;
  assign bus.vsync       = r_pipe[PREFETCH-1].vs;
  assign bus.de          = r_pipe[PREFETCH-1].de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Drives two differently configured generators from a shared clock, reset
//   and pixel enable. Raster A is a small 14x8 frame with positive syncs;
//   raster B is 52x10 with negative syncs, PREFETCH=3 and 8x tiling.
//   The reference tracks a linear pixel index per raster and derives every
//   output from it with plain arithmetic; delayed outputs are the decode of
//   the index PREFETCH enables back, or the reset level if fewer enables
//   have happened since reset.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Raster A
  localparam int A_HA = 8, A_HFP = 2, A_HS = 3, A_HBP = 1;
  localparam int A_VA = 4, A_VFP = 1, A_VS = 2, A_VBP = 1;
  localparam int A_PF = 2, A_SH = 0;
  localparam bit A_HPOL = 1'b1, A_VPOL = 1'b1;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;

  // Raster B
  localparam int B_HA = 40, B_HFP = 4, B_HS = 6, B_HBP = 2;
  localparam int B_VA = 6, B_VFP = 1, B_VS = 2, B_VBP = 1;
  localparam int B_PF = 3, B_SH = 3;
  localparam bit B_HPOL = 1'b0, B_VPOL = 1'b0;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;

  logic clk = 1'b0;
  logic rst;
  logic en;

  int checkCount = 0;
  int errorCount = 0;

  // Reference state: linear pixel index and enables seen since reset.
  int pA, nA, pB, nB;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.HW($clog2(A_HT)), .VW($clog2(A_VT))) ifA ();
  vga_timing_gen_if #(.HW($clog2(B_HT)), .VW($clog2(B_VT))) ifB ();

  assign ifA.en = en;
  assign ifB.en = en;

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .H_POL(A_HPOL), .V_POL(A_VPOL), .PREFETCH(A_PF), .SCALE_SHIFT(A_SH)
  ) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .H_POL(B_HPOL), .V_POL(B_VPOL), .PREFETCH(B_PF), .SCALE_SHIFT(B_SH)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB.master)
  );

  // Single comparison point: counts and reports one check.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
    end
  endtask

  // Expected outputs of one raster, derived from its geometry, the current
  // pixel index p and the number of enables n since reset.
  task automatic checkRaster(
    input string name,
    input int ha, input int hfp, input int hs, input int hbp,
    input int va, input int vfp, input int vs, input int vbp,
    input bit hpol, input bit vpol, input int pf, input int sh,
    input int p, input int n, input bit enV,
    input int oH, input int oV, input int oFv, input int oFx, input int oFy,
    input int oTx, input int oTy, input int oLs, input int oFs,
    input int oHs, input int oVs, input int oDe
  );
    int ht, vt, x, y, fv, fx, fy, q, qx, qy;
    int eHs, eVs, eDe;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    x  = p % ht;
    y  = p / ht;
    fv = (x < ha && y < va) ? 1 : 0;
    fx = fv ? x : 0;
    fy = fv ? y : 0;
    if (n >= pf) begin
      q   = (p - pf + ht * vt) % (ht * vt);
      qx  = q % ht;
      qy  = q / ht;
      eHs = (qx >= ha + hfp && qx < ha + hfp + hs) ? int'(hpol) : int'(!hpol);
      eVs = (qy >= va + vfp && qy < va + vfp + vs) ? int'(vpol) : int'(!vpol);
      eDe = (qx < ha && qy < va) ? 1 : 0;
    end else begin
      eHs = int'(!hpol);
      eVs = int'(!vpol);
      eDe = 0;
    end
    checkOutput({name, ".h_cnt"},       oH,  x);
    checkOutput({name, ".v_cnt"},       oV,  y);
    checkOutput({name, ".fetch_valid"}, oFv, fv);
    checkOutput({name, ".fetch_x"},     oFx, fx);
    checkOutput({name, ".fetch_y"},     oFy, fy);
    checkOutput({name, ".tile_x"},      oTx, fx >> sh);
    checkOutput({name, ".tile_y"},      oTy, fy >> sh);
    checkOutput({name, ".line_start"},  oLs, (enV && x == 0 && y < va) ? 1 : 0);
    checkOutput({name, ".frame_start"}, oFs, (enV && p == 0) ? 1 : 0);
    checkOutput({name, ".hsync"},       oHs, eHs);
    checkOutput({name, ".vsync"},       oVs, eVs);
    checkOutput({name, ".de"},          oDe, eDe);
  endtask

  // One clock: drive inputs on the falling edge, check shortly after, then
  // advance the reference on the rising edge.
  task automatic applyStimulus(input bit enV, input bit rstV);
    @(negedge clk);
    en  = enV;
    rst = rstV;
    if (!rstV) begin
      pA = 0; nA = 0;
      pB = 0; nB = 0;
    end
    #1;
    checkRaster("A", A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP,
                A_HPOL, A_VPOL, A_PF, A_SH, pA, nA, enV,
                int'(ifA.h_cnt), int'(ifA.v_cnt), int'(ifA.fetch_valid),
                int'(ifA.fetch_x), int'(ifA.fetch_y), int'(ifA.tile_x), int'(ifA.tile_y),
                int'(ifA.line_start), int'(ifA.frame_start),
                int'(ifA.hsync), int'(ifA.vsync), int'(ifA.de));
    checkRaster("B", B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP,
                B_HPOL, B_VPOL, B_PF, B_SH, pB, nB, enV,
                int'(ifB.h_cnt), int'(ifB.v_cnt), int'(ifB.fetch_valid),
                int'(ifB.fetch_x), int'(ifB.fetch_y), int'(ifB.tile_x), int'(ifB.tile_y),
                int'(ifB.line_start), int'(ifB.frame_start),
                int'(ifB.hsync), int'(ifB.vsync), int'(ifB.de));
    @(posedge clk);
    if (rst && en) begin
      pA = (pA + 1) % (A_HT * A_VT);
      nA++;
      pB = (pB + 1) % (B_HT * B_VT);
      nB++;
    end
  endtask

  initial begin
    int resetLeft;
    rst = 1'b0;
    en  = 1'b0;
    pA = 0; nA = 0; pB = 0; nB = 0;
    $display("[TB] start");

    // Held in reset, enabled and idle
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // Free running: several frames of A, over one frame of B
    for (int c = 0; c < 600; c++) applyStimulus(1'b1, 1'b1);

    // Enable one cycle in three
    for (int c = 0; c < 360; c++) applyStimulus(c % 3 == 0, 1'b1);

    // Mid-frame reset on raster B, then recovery
    while (pB != 300) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b1);

    // Random enables with occasional short resets
    resetLeft = 0;
    for (int c = 0; c < 1500; c++) begin
      if (resetLeft == 0 && $urandom_range(0, 149) == 0) resetLeft = $urandom_range(1, 3);
      applyStimulus($urandom_range(0, 3) != 0, resetLeft == 0);
      if (resetLeft > 0) resetLeft--;
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
